sr_cmd_seq: RTL and testbench

SR_CMD_SEQ -- requirements
Module: sr_cmd_seq

---
 rtl/sr_cmd_seq_if.sv | 9 +
 rtl/sr_cmd_seq.sv | 127 ++++++++++++
 tb/tb_sr_cmd_seq.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/sr_cmd_seq_if.sv
// Upstream command handshake between a producer and the SR command sequencer.
interface sr_cmd_seq_if;
  logic       req_valid;
  logic [1:0] req_cmd;
  logic       req_ready;

  modport master (output req_valid, output req_cmd, input req_ready);
  modport slave  (input req_valid, input req_cmd, output req_ready);
endinterface

// File: rtl/sr_cmd_seq.sv
// Queues {S,R} commands and replays them on a registered bus to a downstream SR
// flip-flop, holding each for HOLD cycles and inserting a 00 gap between commands.
module sr_cmd_seq #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned HOLD  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  sr_cmd_seq_if.slave            req,
  output logic [1:0]             sr,
  output logic                   q_model,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   err,
  output logic [3:0]             err_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FULL   = LW'(DEPTH);
  localparam logic [3:0]    HOLD_V = 4'(HOLD);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      sr_q, sr_d;
  logic [3:0]      hold_q, hold_d;
  logic            q_model_q, q_model_d;
  logic [LW-1:0]   level_q, level_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            err_q, err_d;
  logic [3:0]      err_cnt_q, err_cnt_d;
  logic [1:0]      mem_q [DEPTH];

  logic accept, push, pop, illegal;

  // Ready depends only on registered occupancy, so a pop never frees a slot same-cycle.
  assign req.req_ready = (level_q != FULL);
  assign accept        = req.req_valid && req.req_ready;
  assign illegal       = accept && (req.req_cmd == 2'b11);
  assign push          = accept && (req.req_cmd != 2'b11);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    hold_d  = hold_q;
    pop     = 1'b0;
    case (state_q)
      // GAP falls straight into the IDLE pop so back-to-back commands cost HOLD+1 cycles.
      IDLE, GAP: begin
        sr_d    = '0;
        state_d = IDLE;
        if (level_q != '0) begin
          pop     = 1'b1;
          sr_d    = mem_q[rd_ptr_q];
          hold_d  = HOLD_V;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (hold_q <= 4'd1) begin
          sr_d    = '0;
          state_d = GAP;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
      default: begin
        sr_d    = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d   = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    err_d     = illegal;
    err_cnt_d = (illegal && err_cnt_q != 4'hF) ? err_cnt_q + 4'd1 : err_cnt_q;
    q_model_d = q_model_q;
    case (sr_q)
      2'b10:   q_model_d = 1'b1;
      2'b01:   q_model_d = 1'b0;
      default: q_model_d = q_model_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      hold_q    <= '0;
      q_model_q <= 1'b0;
      level_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      hold_q    <= hold_d;
      q_model_q <= q_model_d;
      level_q   <= level_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      if (push) mem_q[wr_ptr_q] <= req.req_cmd;
    end
  end

  assign sr      = sr_q;
  assign q_model = q_model_q;
  assign busy    = (level_q != '0) || (state_q != IDLE);
  assign level   = level_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_sr_cmd_seq.sv
// Directed checks for sr_cmd_seq: DEPTH=4/HOLD=1 main instance plus a HOLD=3 instance.
module tb_sr_cmd_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sr, sr3;
  logic       q_model, q_model3, busy, busy3, err, err3;
  logic [2:0] level, level3;
  logic [3:0] err_cnt, err_cnt3;

  int checks = 0;
  int errors = 0;

  sr_cmd_seq_if rif ();
  sr_cmd_seq_if rif3 ();

  sr_cmd_seq #(.DEPTH(4), .HOLD(1)) dut (
    .clk(clk), .rst(rst), .req(rif), .sr(sr), .q_model(q_model), .busy(busy),
    .level(level), .err(err), .err_cnt(err_cnt)
  );

  sr_cmd_seq #(.DEPTH(4), .HOLD(3)) dut3 (
    .clk(clk), .rst(rst), .req(rif3), .sr(sr3), .q_model(q_model3), .busy(busy3),
    .level(level3), .err(err3), .err_cnt(err_cnt3)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rif.req_valid  = 1'b0;
    rif.req_cmd    = 2'b00;
    rif3.req_valid = 1'b0;
    rif3.req_cmd   = 2'b00;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (sr !== 2'b00) begin errors++; $display("FAIL reset_sr got %b exp 00", sr); end
    checks++; if (q_model !== 1'b0) begin errors++; $display("FAIL reset_q got %b exp 0", q_model); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (err !== 1'b0 || err_cnt !== 4'd0) begin errors++; $display("FAIL reset_err got %b/%0d exp 0/0", err, err_cnt); end
    checks++; if (rif.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", rif.req_ready); end
  endtask

  task automatic test_single();
    do_reset();
    rif.req_valid = 1'b1; rif.req_cmd = 2'b10;
    tick();                                   // edge 1: accepted
    rif.req_valid = 1'b0;
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL single_level1 got %0d exp 1", level); end
    checks++; if (sr !== 2'b00) begin errors++; $display("FAIL single_sr1 got %b exp 00", sr); end
    tick();                                   // edge 2
    checks++; if (sr !== 2'b10) begin errors++; $display("FAIL single_sr2 got %b exp 10", sr); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL single_level2 got %0d exp 0", level); end
    checks++; if (q_model !== 1'b0) begin errors++; $display("FAIL single_q2 got %b exp 0", q_model); end
    tick();                                   // edge 3
    checks++; if (sr !== 2'b00) begin errors++; $display("FAIL single_sr3 got %b exp 00", sr); end
    checks++; if (q_model !== 1'b1) begin errors++; $display("FAIL single_q3 got %b exp 1", q_model); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy3 got %b exp 1", busy); end
    tick();                                   // edge 4
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy4 got %b exp 0", busy); end
  endtask

  task automatic test_illegal();
    do_reset();
    rif.req_valid = 1'b1; rif.req_cmd = 2'b11;
    tick();
    rif.req_valid = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err got %b exp 1", err); end
    checks++; if (err_cnt !== 4'd1) begin errors++; $display("FAIL illegal_cnt got %0d exp 1", err_cnt); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL illegal_level got %0d exp 0", level); end
    checks++; if (rif.req_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready got %b exp 1", rif.req_ready); end
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL illegal_err_pulse got %b exp 0", err); end
    checks++; if (sr !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL illegal_sr got %b busy %b exp 00 0", sr, busy); end
    do_reset();
    rif.req_valid = 1'b1; rif.req_cmd = 2'b11;
    for (int i = 0; i < 14; i++) tick();
    checks++; if (err_cnt !== 4'd14) begin errors++; $display("FAIL illegal_cnt14 got %0d exp 14", err_cnt); end
    for (int i = 0; i < 3; i++) tick();
    rif.req_valid = 1'b0;
    checks++; if (err_cnt !== 4'd15) begin errors++; $display("FAIL illegal_sat got %0d exp 15", err_cnt); end
    checks++; if (sr !== 2'b00 || level !== 3'd0) begin errors++; $display("FAIL illegal_nostore sr %b level %0d exp 00 0", sr, level); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] cmds   [3] = '{2'b10, 2'b00, 2'b01};
    logic [1:0] exp_sr [6] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
    logic       exp_q  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int e = 1; e <= 7; e++) begin
      if (e <= 3) begin rif.req_valid = 1'b1; rif.req_cmd = cmds[e-1]; end
      else rif.req_valid = 1'b0;
      tick();
      if (e >= 2) begin
        checks++;
        if (sr !== exp_sr[e-2]) begin errors++; $display("FAIL b2b_sr_e%0d got %b exp %b", e, sr, exp_sr[e-2]); end
        checks++;
        if (q_model !== exp_q[e-2]) begin errors++; $display("FAIL b2b_q_e%0d got %b exp %b", e, q_model, exp_q[e-2]); end
      end
    end
    rif.req_valid = 1'b0;
  endtask

  task automatic test_fill();
    int accepts = 0;
    int shown   = 0;
    int max_lvl = 0;
    bit drained = 0;
    do_reset();
    rif.req_valid = 1'b1; rif.req_cmd = 2'b10;
    for (int i = 0; i < 12; i++) begin
      if (rif.req_ready === 1'b1) accepts++;
      tick();
      if (sr === 2'b10) shown++;
      if (int'(level) > max_lvl) max_lvl = int'(level);
      if (level === 3'd4) begin
        checks++;
        if (rif.req_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_full got %b exp 0", rif.req_ready); end
      end
    end
    rif.req_valid = 1'b0;
    checks++; if (accepts != 9) begin errors++; $display("FAIL fill_accepts got %0d exp 9", accepts); end
    checks++; if (max_lvl != 4) begin errors++; $display("FAIL fill_maxlevel got %0d exp 4", max_lvl); end
    for (int i = 0; i < 40 && !drained; i++) begin
      tick();
      if (sr === 2'b10) shown++;
      if (busy === 1'b0) drained = 1;
    end
    checks++; if (!drained) begin errors++; $display("FAIL fill_drain_timeout busy %b exp 0", busy); end
    checks++; if (shown != 9) begin errors++; $display("FAIL fill_pops got %0d exp 9", shown); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] cmds [6] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
    int leaks = 0;
    do_reset();
    for (int e = 1; e <= 6; e++) begin
      rif.req_valid = 1'b1; rif.req_cmd = cmds[e-1];
      tick();
    end
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL mid_pre_level got %0d exp 3", level); end
    checks++; if (sr !== 2'b10) begin errors++; $display("FAIL mid_pre_sr got %b exp 10", sr); end
    rst = 1'b1; rif.req_valid = 1'b1; rif.req_cmd = 2'b11;
    tick();
    rst = 1'b0; rif.req_valid = 1'b0;
    checks++; if (sr !== 2'b00) begin errors++; $display("FAIL mid_sr got %b exp 00", sr); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL mid_level got %0d exp 0", level); end
    checks++; if (q_model !== 1'b0) begin errors++; $display("FAIL mid_q got %b exp 0", q_model); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", busy); end
    checks++; if (err !== 1'b0 || err_cnt !== 4'd0) begin errors++; $display("FAIL mid_err got %b/%0d exp 0/0", err, err_cnt); end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sr !== 2'b00) leaks++;
    end
    checks++; if (leaks != 0) begin errors++; $display("FAIL mid_leak got %0d exp 0", leaks); end
  endtask

  task automatic test_hold3();
    logic [1:0] exp_sr [5] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
    do_reset();
    rif3.req_valid = 1'b1; rif3.req_cmd = 2'b01;
    tick();
    rif3.req_valid = 1'b0;
    checks++; if (sr3 !== 2'b00) begin errors++; $display("FAIL hold3_sr_e1 got %b exp 00", sr3); end
    for (int e = 2; e <= 6; e++) begin
      tick();
      checks++;
      if (sr3 !== exp_sr[e-2]) begin errors++; $display("FAIL hold3_sr_e%0d got %b exp %b", e, sr3, exp_sr[e-2]); end
    end
    checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL hold3_busy got %b exp 0", busy3); end
  endtask

  initial begin
    rif.req_valid  = 1'b0; rif.req_cmd  = 2'b00;
    rif3.req_valid = 1'b0; rif3.req_cmd = 2'b00;
    test_reset();
    test_single();
    test_illegal();
    test_back_to_back();
    test_fill();
    test_reset_mid();
    test_hold3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
